// File: rtl/segment_cipher_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : segment_cipher_sequencer
// Brief   : Walks a latched message/key block through a narrow cipher engine
//           one segment at a time and reassembles the per-segment results.
// Rev     : 1.0  initial release
// ============================================================================
module segment_cipher_sequencer #(
    parameter int SEG_W   = 16,
    parameter int NSEG    = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [SEG_W*NSEG-1:0]     msg,
    input  logic [SEG_W*NSEG-1:0]     key,
    output logic                      seg_valid,
    input  logic                      seg_ready,
    output logic [SEG_W-1:0]          seg_msg,
    output logic [SEG_W-1:0]          seg_key,
    output logic [$clog2(NSEG)-1:0]   seg_idx,
    input  logic                      res_valid,
    input  logic [SEG_W-1:0]          res_data,
    output logic [SEG_W*NSEG-1:0]     result,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int BLK_W = SEG_W * NSEG;
    localparam int IDX_W = $clog2(NSEG);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NSEG - 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [BLK_W-1:0]   msg_q,    msg_d;
    logic [BLK_W-1:0]   key_q,    key_d;
    logic [BLK_W-1:0]   result_q, result_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic               err_q,    err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            msg_q    <= '0;
            key_q    <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            msg_q    <= msg_d;
            key_q    <= key_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        msg_d    = msg_q;
        key_d    = key_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    msg_d    = msg;
                    key_d    = key;
                    idx_d    = '0;
                    result_d = '0;
                    cnt_d    = '0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (seg_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // A result arriving on the final allowed cycle still completes the segment.
                if (res_valid) begin
                    result_d[idx_q*SEG_W +: SEG_W] = res_data;
                    if (idx_q == C_LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = S_ISSUE;
                    end
                end else if (cnt_q == C_CNT_LAST) begin
                    idx_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                idx_d   = '0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign seg_valid = (state_q == S_ISSUE);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign result    = result_q;
    assign seg_idx   = idx_q;
    assign seg_msg   = msg_q[idx_q*SEG_W +: SEG_W];
    assign seg_key   = key_q[idx_q*SEG_W +: SEG_W];

endmodule
`default_nettype wire
